// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard controller: MDU FSM state encodings and hazard priority codes.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MduIdle = 2'd0,
    MduBusy = 2'd1,
    MduDone = 2'd2
  } mdu_state_e;

  typedef enum logic [2:0] {
    PrioNone = 3'd0,
    PrioMem  = 3'd1,
    PrioMdu  = 3'd2,
    PrioJump = 3'd3,
    PrioLu   = 3'd4
  } hazard_prio_e;

  typedef struct packed {
    logic f;
    logic d;
    logic e;
    logic m;
    logic w;
  } stage_vec_t;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_fsm.sv
// Tracks MUL/DIV residency in E: raises mdu_stall until the result is ready, then mdu_done.
module hazard_ctrl_mdu_busy_fsm
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic mem_wait_i,
  output logic mdu_stall_o,
  output logic mdu_done_o
);

  localparam int unsigned CntW     = $clog2(MDU_LAT + 1);
  localparam int unsigned CntInitI = (MDU_LAT >= 3) ? MDU_LAT - 3 : 0;
  localparam logic [CntW-1:0] CntInit = CntW'(CntInitI);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mdu_stall_o = 1'b0;
    mdu_done_o  = 1'b0;
    unique case (state_q)
      MduIdle: begin
        // A start while M waits is dropped; E is held so it is seen again next cycle.
        if (start_i && !mem_wait_i) begin
          mdu_stall_o = 1'b1;
          if (MDU_LAT == 2) begin
            state_d = MduDone;
          end else begin
            state_d = MduBusy;
            cnt_d   = CntInit;
          end
        end
      end
      MduBusy: begin
        mdu_stall_o = 1'b1;
        if (cnt_q == '0) begin
          state_d = MduDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      MduDone: begin
        mdu_done_o = 1'b1;
        if (!mem_wait_i) begin
          state_d = MduIdle;
        end
      end
      default: state_d = MduIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MduIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use, MUL/DIV, memory wait and redirect flush.
// Define HAZARD_PERF_EN to build the saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LU_DEPTH = 1,
  parameter int unsigned MDU_LAT  = 4,
  parameter int unsigned PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              execute_i_need_jump,
  input  logic              execute_i_mdu_start,
  input  logic              mem_i_wait,
  input  logic [REG_AW-1:0] decode_i_rs1,
  input  logic [REG_AW-1:0] decode_i_rs2,
  input  logic              decode_i_rs1_ren,
  input  logic              decode_i_rs2_ren,
  input  logic [REG_AW-1:0] regE_i_rd,
  input  logic [REG_AW-1:0] regM_i_rd,
  input  logic              regE_i_is_load,
  input  logic              regM_i_is_load,
  output logic              ctrl_o_regF_stall,
  output logic              ctrl_o_regD_stall,
  output logic              ctrl_o_regE_stall,
  output logic              ctrl_o_regM_stall,
  output logic              ctrl_o_regW_stall,
  output logic              ctrl_o_regF_bubble,
  output logic              ctrl_o_regD_bubble,
  output logic              ctrl_o_regE_bubble,
  output logic              ctrl_o_regM_bubble,
  output logic              ctrl_o_regW_bubble,
  output logic              ctrl_o_mdu_done,
  output logic [PERF_W-1:0] ctrl_o_perf_lu,
  output logic [PERF_W-1:0] ctrl_o_perf_mdu,
  output logic [PERF_W-1:0] ctrl_o_perf_mem,
  output logic [PERF_W-1:0] ctrl_o_perf_flush
);

  logic         mdu_stall;
  logic         hit_rs1, hit_rs2, load_use;
  hazard_prio_e prio;
  stage_vec_t   stall, bubble;

  hazard_ctrl_mdu_busy_fsm #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (execute_i_mdu_start),
    .mem_wait_i (mem_i_wait),
    .mdu_stall_o(mdu_stall),
    .mdu_done_o (ctrl_o_mdu_done)
  );

  assign hit_rs1 = decode_i_rs1_ren && (decode_i_rs1 != '0) &&
                   ((regE_i_is_load && (decode_i_rs1 == regE_i_rd)) ||
                    ((LU_DEPTH == 2) && regM_i_is_load && (decode_i_rs1 == regM_i_rd)));
  assign hit_rs2 = decode_i_rs2_ren && (decode_i_rs2 != '0) &&
                   ((regE_i_is_load && (decode_i_rs2 == regE_i_rd)) ||
                    ((LU_DEPTH == 2) && regM_i_is_load && (decode_i_rs2 == regM_i_rd)));
  assign load_use = hit_rs1 || hit_rs2;

  always_comb begin
    if (mem_i_wait) begin
      prio = PrioMem;
    end else if (mdu_stall) begin
      prio = PrioMdu;
    end else if (execute_i_need_jump) begin
      prio = PrioJump;
    end else if (load_use) begin
      prio = PrioLu;
    end else begin
      prio = PrioNone;
    end
  end

  always_comb begin
    stall  = '0;
    bubble = '0;
    unique case (prio)
      PrioMem: begin
        stall    = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b0};
        bubble.w = 1'b1;
      end
      PrioMdu: begin
        stall    = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b0, w: 1'b0};
        bubble.m = 1'b1;
      end
      PrioJump: begin
        bubble.d = 1'b1;
        bubble.e = 1'b1;
      end
      PrioLu: begin
        stall.f  = 1'b1;
        stall.d  = 1'b1;
        bubble.e = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_o_regF_stall  = stall.f;
  assign ctrl_o_regD_stall  = stall.d;
  assign ctrl_o_regE_stall  = stall.e;
  assign ctrl_o_regM_stall  = stall.m;
  assign ctrl_o_regW_stall  = stall.w;
  assign ctrl_o_regF_bubble = bubble.f;
  assign ctrl_o_regD_bubble = bubble.d;
  assign ctrl_o_regE_bubble = bubble.e;
  assign ctrl_o_regM_bubble = bubble.m;
  assign ctrl_o_regW_bubble = bubble.w;

`ifdef HAZARD_PERF_EN
  // Index order: 0 load-use, 1 mdu, 2 mem, 3 flush.
  logic [3:0][PERF_W-1:0] perf_q, perf_d;
  logic [3:0]             perf_hit;

  assign perf_hit = {prio == PrioJump, prio == PrioMem, prio == PrioMdu, prio == PrioLu};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      perf_d[i] = (perf_hit[i] && (perf_q[i] != '1)) ? perf_q[i] + PERF_W'(1) : perf_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign ctrl_o_perf_lu    = perf_q[0];
  assign ctrl_o_perf_mdu   = perf_q[1];
  assign ctrl_o_perf_mem   = perf_q[2];
  assign ctrl_o_perf_flush = perf_q[3];
`else
  assign ctrl_o_perf_lu    = '0;
  assign ctrl_o_perf_mdu   = '0;
  assign ctrl_o_perf_mem   = '0;
  assign ctrl_o_perf_flush = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one instance with LU_DEPTH=1, one with LU_DEPTH=2.
module tb_hazard_ctrl;

  localparam logic [9:0] VecNone = 10'b00000_00000;
  localparam logic [9:0] VecLu   = 10'b11000_00100;
  localparam logic [9:0] VecMdu  = 10'b11100_00010;
  localparam logic [9:0] VecJump = 10'b00000_01100;
  localparam logic [9:0] VecMem  = 10'b11110_00001;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] ExpPerfLu = 32'd3;
`else
  localparam logic [31:0] ExpPerfLu = 32'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       jump, start, mem_wait;
  logic [4:0] rs1, rs2, e_rd, m_rd;
  logic       ren1, ren2, e_ld, m_ld;

  logic [9:0]  vec1, vec2;
  logic        done1, done2;
  logic [31:0] lu1, mdu1, mem1, fl1, lu2, mdu2, mem2, fl2;

  logic fs1, ds1, es1, ms1, ws1, fb1, db1, eb1, mb1, wb1;
  logic fs2, ds2, es2, ms2, ws2, fb2, db2, eb2, mb2, wb2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign vec1 = {fs1, ds1, es1, ms1, ws1, fb1, db1, eb1, mb1, wb1};
  assign vec2 = {fs2, ds2, es2, ms2, ws2, fb2, db2, eb2, mb2, wb2};

  hazard_ctrl #(.REG_AW(5), .LU_DEPTH(1), .MDU_LAT(4), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .execute_i_need_jump(jump), .execute_i_mdu_start(start), .mem_i_wait(mem_wait),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(ren1), .decode_i_rs2_ren(ren2),
    .regE_i_rd(e_rd), .regM_i_rd(m_rd), .regE_i_is_load(e_ld), .regM_i_is_load(m_ld),
    .ctrl_o_regF_stall(fs1), .ctrl_o_regD_stall(ds1), .ctrl_o_regE_stall(es1),
    .ctrl_o_regM_stall(ms1), .ctrl_o_regW_stall(ws1),
    .ctrl_o_regF_bubble(fb1), .ctrl_o_regD_bubble(db1), .ctrl_o_regE_bubble(eb1),
    .ctrl_o_regM_bubble(mb1), .ctrl_o_regW_bubble(wb1),
    .ctrl_o_mdu_done(done1),
    .ctrl_o_perf_lu(lu1), .ctrl_o_perf_mdu(mdu1), .ctrl_o_perf_mem(mem1),
    .ctrl_o_perf_flush(fl1)
  );

  hazard_ctrl #(.REG_AW(5), .LU_DEPTH(2), .MDU_LAT(4), .PERF_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .execute_i_need_jump(jump), .execute_i_mdu_start(start), .mem_i_wait(mem_wait),
    .decode_i_rs1(rs1), .decode_i_rs2(rs2),
    .decode_i_rs1_ren(ren1), .decode_i_rs2_ren(ren2),
    .regE_i_rd(e_rd), .regM_i_rd(m_rd), .regE_i_is_load(e_ld), .regM_i_is_load(m_ld),
    .ctrl_o_regF_stall(fs2), .ctrl_o_regD_stall(ds2), .ctrl_o_regE_stall(es2),
    .ctrl_o_regM_stall(ms2), .ctrl_o_regW_stall(ws2),
    .ctrl_o_regF_bubble(fb2), .ctrl_o_regD_bubble(db2), .ctrl_o_regE_bubble(eb2),
    .ctrl_o_regM_bubble(mb2), .ctrl_o_regW_bubble(wb2),
    .ctrl_o_mdu_done(done2),
    .ctrl_o_perf_lu(lu2), .ctrl_o_perf_mdu(mdu2), .ctrl_o_perf_mem(mem2),
    .ctrl_o_perf_flush(fl2)
  );

  task automatic clear_inputs();
    jump = 0; start = 0; mem_wait = 0;
    rs1 = 0; rs2 = 0; ren1 = 0; ren2 = 0;
    e_rd = 0; m_rd = 0; e_ld = 0; m_ld = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    #2;
    n_checks++;
    if (vec1 !== VecNone) $display("FAIL reset_vec: got %b want %b", vec1, VecNone);
    else n_pass++;
    n_checks++;
    if (done1 !== 1'b0 || done2 !== 1'b0)
      $display("FAIL reset_done: got %b/%b want 0/0", done1, done2);
    else n_pass++;
    n_checks++;
    if ({lu1, mdu1, mem1, fl1} !== 128'd0)
      $display("FAIL reset_perf: got %h want 0", {lu1, mdu1, mem1, fl1});
    else n_pass++;
    next_cycle();
    rst_n = 1;
    next_cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    e_ld = 1; e_rd = 5; rs1 = 5; ren1 = 1;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecLu) $display("FAIL lu_rs1: got %b want %b", vec1, VecLu);
    else n_pass++;
    next_cycle();
    // The load has moved on to M; depth 1 no longer sees it.
    e_ld = 0; m_ld = 1; m_rd = 5;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecNone) $display("FAIL lu_clear: got %b want %b", vec1, VecNone);
    else n_pass++;
    next_cycle();
    clear_inputs();
    e_ld = 1; e_rd = 0; rs1 = 0; ren1 = 1;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecNone) $display("FAIL lu_x0: got %b want %b", vec1, VecNone);
    else n_pass++;
    next_cycle();
    clear_inputs();
    e_ld = 1; e_rd = 9; rs1 = 9; ren1 = 0; rs2 = 9; ren2 = 1;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecLu) $display("FAIL lu_rs2: got %b want %b", vec1, VecLu);
    else n_pass++;
    ren2 = 0;
    #1;
    n_checks++;
    if (vec1 !== VecNone) $display("FAIL lu_unused: got %b want %b", vec1, VecNone);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_lu_depth();
    clear_inputs();
    m_ld = 1; m_rd = 7; rs1 = 7; ren1 = 1;
    @(negedge clk);
    n_checks++;
    if (vec2 !== VecLu) $display("FAIL lu_depth2: got %b want %b", vec2, VecLu);
    else n_pass++;
    n_checks++;
    if (vec1 !== VecNone) $display("FAIL lu_depth1: got %b want %b", vec1, VecNone);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_mdu();
    logic [9:0] exp_vec;
    clear_inputs();
    start = 1;
    for (int c = 0; c < 4; c++) begin
      exp_vec = (c < 3) ? VecMdu : VecNone;
      @(negedge clk);
      n_checks++;
      if (vec1 !== exp_vec || done1 !== (c == 3))
        $display("FAIL mdu_seq c%0d: got %b/%b want %b/%b", c, vec1, done1, exp_vec, c == 3);
      else n_pass++;
      next_cycle();
    end
    start = 0;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecNone || done1 !== 1'b0)
      $display("FAIL mdu_idle: got %b/%b want %b/0", vec1, done1, VecNone);
    else n_pass++;
    next_cycle();
    // Start under mem_wait is ignored; the full latency begins once M is released.
    start = 1; mem_wait = 1;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecMem || done1 !== 1'b0)
      $display("FAIL mdu_start_memwait: got %b/%b want %b/0", vec1, done1, VecMem);
    else n_pass++;
    next_cycle();
    mem_wait = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (vec1 !== VecMdu) $display("FAIL mdu_stall2 c%0d: got %b want %b", c, vec1, VecMdu);
      else n_pass++;
      next_cycle();
    end
    mem_wait = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (vec1 !== VecMem || done1 !== 1'b1)
        $display("FAIL mdu_done_hold c%0d: got %b/%b want %b/1", c, vec1, done1, VecMem);
      else n_pass++;
      next_cycle();
    end
    mem_wait = 0;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecNone || done1 !== 1'b1)
      $display("FAIL mdu_done_release: got %b/%b want %b/1", vec1, done1, VecNone);
    else n_pass++;
    next_cycle();
    start = 0;
    @(negedge clk);
    n_checks++;
    if (done1 !== 1'b0) $display("FAIL mdu_back_idle: got %b want 0", done1);
    else n_pass++;
    next_cycle();
  endtask

  task automatic test_priority();
    clear_inputs();
    e_ld = 1; e_rd = 5; rs1 = 5; ren1 = 1; jump = 1;
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecJump) $display("FAIL jump_over_lu: got %b want %b", vec1, VecJump);
    else n_pass++;
    mem_wait = 1;
    #1;
    n_checks++;
    if (vec1 !== VecMem) $display("FAIL mem_over_all: got %b want %b", vec1, VecMem);
    else n_pass++;
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_reset_busy();
    clear_inputs();
    start = 1;
    next_cycle();
    @(negedge clk);
    n_checks++;
    if (vec1 !== VecMdu) $display("FAIL busy_before_rst: got %b want %b", vec1, VecMdu);
    else n_pass++;
    #1;
    rst_n = 0; start = 0;
    #1;
    n_checks++;
    if (vec1 !== VecNone || done1 !== 1'b0)
      $display("FAIL busy_async_rst: got %b/%b want %b/0", vec1, done1, VecNone);
    else n_pass++;
    next_cycle();
    rst_n = 1; start = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (vec1 !== ((c < 3) ? VecMdu : VecNone) || done1 !== (c == 3))
        $display("FAIL mdu_restart c%0d: got %b/%b want done=%b", c, vec1, done1, c == 3);
      else n_pass++;
      next_cycle();
    end
    start = 0;
    next_cycle();
  endtask

  task automatic test_perf();
    clear_inputs();
    rst_n = 0;
    #1;
    rst_n = 1;
    e_ld = 1; e_rd = 3; rs2 = 3; ren2 = 1;
    for (int c = 0; c < 3; c++) next_cycle();
    clear_inputs();
    @(negedge clk);
    n_checks++;
    if (lu1 !== ExpPerfLu) $display("FAIL perf_lu: got %0d want %0d", lu1, ExpPerfLu);
    else n_pass++;
    n_checks++;
    if (fl1 !== 32'd0 || mdu1 !== 32'd0)
      $display("FAIL perf_other: got %0d/%0d want 0/0", fl1, mdu1);
    else n_pass++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_lu_depth();
    test_mdu();
    test_priority();
    test_reset_busy();
    test_perf();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
